memc_arb: RTL

Two-port arbiter that shares the single-port memory controller between two requesters, e.g. the 6502 core on port 0 and a loader/DMA or video fetch on port 1.
- Accepts one transaction at a time, issues it to the controller as a one-cycle enable pulse, and returns read data to the winning port.
- Sits directly upstream of the memory controller's memc_rd_enable/memc_wr_enable/memc_addr/memc_wr_data interface.
- Holds off all grants while the controller reports busy (reset/BIST/error).

---
 rtl/memc_pkg.sv | 15 +
 rtl/memc_arb_if.sv | 52 +++++
 rtl/memc_rr_pick.sv | 20 ++
 rtl/memc_arb.sv | 129 ++++++++++++
 4 files changed

// File: rtl/memc_pkg.sv
// Shared types and defaults for the two-port memory-controller arbiter.
package memc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RETURN  = 2'd3
    } state_e;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 16;
    localparam int unsigned LAT_CNT_W      = 4;

endpackage

// File: rtl/memc_arb_if.sv
// Requester ports plus the memory-controller command/data interface.
interface memc_arb_if
    import memc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic                  req0_valid;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_rdata;
    logic                  req0_rvalid;

    logic                  req1_valid;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_rdata;
    logic                  req1_rvalid;

    logic                  memc_busy;
    logic                  memc_rd_enable;
    logic                  memc_wr_enable;
    logic [ADDR_WIDTH-1:0] memc_addr;
    logic [DATA_WIDTH-1:0] memc_wr_data;
    logic [DATA_WIDTH-1:0] memc_rd_data;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, req0_rdata, req0_rvalid,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, req1_rdata, req1_rvalid,
        input  memc_busy, memc_rd_data,
        output memc_rd_enable, memc_wr_enable, memc_addr, memc_wr_data
    );

    // Requesters plus controller, seen from outside the arbiter.
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, req0_rdata, req0_rvalid,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, req1_rdata, req1_rvalid,
        output memc_busy, memc_rd_data,
        input  memc_rd_enable, memc_wr_enable, memc_addr, memc_wr_data
    );

endinterface

// File: rtl/memc_rr_pick.sv
// Combinational 2-way pick: fixed priority to port 0, or the port not granted last.
module memc_rr_pick (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_gnt_i,
    input  logic fixed_prio_i,
    output logic gnt_o,
    output logic any_valid_o
);

    always_comb begin
        any_valid_o = valid0_i | valid1_i;
        if (valid0_i && valid1_i) begin
            gnt_o = fixed_prio_i ? 1'b0 : ~last_gnt_i;
        end else begin
            gnt_o = valid1_i;
        end
    end

endmodule

// File: rtl/memc_arb.sv
// Two-port arbiter in front of the single-port memory controller: one
// transaction at a time, one-cycle command pulse, read data routed back.
module memc_arb
    import memc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned RD_LATENCY = 3,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic       memc_clk,
    input  logic       memc_reset,
    memc_arb_if.slave  bus
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(RD_LATENCY - 1);

    state_e                 state_q;
    logic                   last_gnt_q;
    logic                   win_q;
    logic                   we_q;
    logic [LAT_CNT_W-1:0]   cnt_q;
    logic                   ready0_q, ready1_q;
    logic                   rd_en_q, wr_en_q;
    logic                   rvalid0_q, rvalid1_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  rdata0_q, rdata1_q;

    logic                   pick_gnt, pick_any;
    logic                   sel_we_d;
    logic [ADDR_WIDTH-1:0]  sel_addr_d;
    logic [DATA_WIDTH-1:0]  sel_wdata_d;

    memc_rr_pick u_pick (
        .valid0_i     (bus.req0_valid),
        .valid1_i     (bus.req1_valid),
        .last_gnt_i   (last_gnt_q),
        .fixed_prio_i (FIXED_PRIO != 0),
        .gnt_o        (pick_gnt),
        .any_valid_o  (pick_any)
    );

    always_comb begin
        sel_we_d    = pick_gnt ? bus.req1_we    : bus.req0_we;
        sel_addr_d  = pick_gnt ? bus.req1_addr  : bus.req0_addr;
        sel_wdata_d = pick_gnt ? bus.req1_wdata : bus.req0_wdata;
    end

    always_ff @(posedge memc_clk or negedge memc_reset) begin
        if (!memc_reset) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            ready0_q   <= 1'b0;
            ready1_q   <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            // All pulse outputs default low; each is raised for exactly one cycle.
            ready0_q  <= 1'b0;
            ready1_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any && !bus.memc_busy) begin
                        state_q    <= ISSUE;
                        win_q      <= pick_gnt;
                        last_gnt_q <= pick_gnt;
                        we_q       <= sel_we_d;
                        addr_q     <= sel_addr_d;
                        wdata_q    <= sel_wdata_d;
                        ready0_q   <= ~pick_gnt;
                        ready1_q   <= pick_gnt;
                        wr_en_q    <= sel_we_d;
                        rd_en_q    <= ~sel_we_d;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT_RD;
                        cnt_q   <= LAT_INIT;
                    end
                end
                WAIT_RD: begin
                    if (cnt_q == '0) begin
                        state_q <= RETURN;
                        if (win_q) begin
                            rdata1_q  <= bus.memc_rd_data;
                            rvalid1_q <= 1'b1;
                        end else begin
                            rdata0_q  <= bus.memc_rd_data;
                            rvalid0_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RETURN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready     = ready0_q;
    assign bus.req1_ready     = ready1_q;
    assign bus.req0_rvalid    = rvalid0_q;
    assign bus.req1_rvalid    = rvalid1_q;
    assign bus.req0_rdata     = rdata0_q;
    assign bus.req1_rdata     = rdata1_q;
    assign bus.memc_rd_enable = rd_en_q;
    assign bus.memc_wr_enable = wr_en_q;
    assign bus.memc_addr      = addr_q;
    assign bus.memc_wr_data   = wdata_q;

endmodule
